// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op_sel codes,
// control FSM states and datapath mode, plus small op-decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } core_mode_e;

  // Reserved codes (11x) have op[2]=1, so they never count as arithmetic.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return ~op[2] & op[0];
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_if.sv
// CPU-side bundle of the multiply/divide unit: request inputs, HI/LO results
// and handshake status. The unit takes the slave view, the control unit the master.
interface muldiv_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hilo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall;

  modport master (
    output op_valid, op_sel, a, b, rd_hilo,
    input  hi, lo, busy, done, div_by_zero, stall
  );

  modport slave (
    input  op_valid, op_sel, a, b, rd_hilo,
    output hi, lo, busy, done, div_by_zero, stall
  );
endinterface

// File: rtl/muldiv_hilo_unit_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide, one
// bit per step, sharing a single 2*WIDTH accumulator {upper, lower}.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  core_mode_e       i_mode,
  input  logic [WIDTH-1:0] i_opa,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // Multiply: r_op = multiplicand, lower half starts as multiplier.
  // Divide:   r_op = divisor, lower half starts as dividend and fills with quotient.
  core_mode_e         r_mode;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_op;

  logic [WIDTH-1:0]   w_upper;
  logic [WIDTH-1:0]   w_lower;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_upper = r_acc[2*WIDTH-1:WIDTH];
  assign w_lower = r_acc[WIDTH-1:0];

  assign w_addend   = r_acc[0] ? {1'b0, r_op} : '0;
  assign w_sum      = {1'b0, w_upper} + w_addend;
  assign w_mul_next = {w_sum, w_lower[WIDTH-1:1]};

  // Remainder stays below the divisor, so the difference fits WIDTH bits
  // whenever the trial subtraction succeeds.
  assign w_shift    = {w_upper, w_lower[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_op});
  assign w_diff     = w_shift[WIDTH-1:0] - r_op;
  assign w_rem_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_div_next = {w_rem_next, w_lower[WIDTH-2:0], w_ge};

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_MUL;
      r_acc  <= '0;
      r_op   <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_op   <= (i_mode == MODE_MUL) ? i_opa : i_opb;
      r_acc  <= {{WIDTH{1'b0}}, ((i_mode == MODE_MUL) ? i_opb : i_opa)};
    end else if (i_step) begin
      r_acc  <= (r_mode == MODE_DIV) ? w_div_next : w_mul_next;
    end
  end

  assign o_hi = w_upper;
  assign o_lo = w_lower;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multiply/divide unit with private HI/LO: control FSM, sign pre/post
// correction around the unsigned core, mthi/mtlo writes and pipeline stall.
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_hilo_unit_if.slave  bus
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dbz_pulse;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;

  logic             w_busy;
  logic             w_arith;
  logic             w_div;
  logic             w_signed;
  logic             w_idle_req;
  logic             w_accept;
  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_load;
  logic             w_step;
  core_mode_e       w_mode;

  logic [WIDTH-1:0]   w_core_hi;
  logic [WIDTH-1:0]   w_core_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  assign w_busy     = (r_state != S_IDLE);
  assign w_arith    = is_arith(bus.op_sel);
  assign w_div      = is_div_op(bus.op_sel);
  assign w_signed   = is_signed_op(bus.op_sel);
  // done blocks the still-held instruction that just completed.
  assign w_idle_req = bus.op_valid & ~w_busy & ~r_done;
  assign w_accept   = w_idle_req & w_arith;
  assign w_b_zero   = (bus.b == '0);

  // The most-negative value maps to 2^(WIDTH-1), which is still exact unsigned.
  assign w_a_neg = w_signed & bus.a[WIDTH-1];
  assign w_b_neg = w_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;
  assign w_mode  = w_div ? MODE_DIV : MODE_MUL;

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_mode (w_mode),
    .i_opa  (w_a_mag),
    .i_opb  (w_b_mag),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_state_next = (w_div & w_b_zero) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) w_state_next = S_FIN;
      end
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load)      r_cnt <= CNT_INIT;
      else if (w_step) r_cnt <= r_cnt - CNT_LAST;
    end
  end

  // Sign flags captured at acceptance; operands are never looked at again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_load) begin
      r_is_div <= w_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg & w_div;
      r_dbz    <= w_div & w_b_zero;
    end
  end

  assign w_prod     = {w_core_hi, w_core_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -w_core_lo : w_core_lo;
  assign w_rem_fix  = r_neg_r ? -w_core_hi : w_core_hi;
  assign w_hi_fix   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_lo_fix   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= (r_state == S_FIN);
      r_dbz_pulse <= (r_state == S_FIN) & r_dbz;
      if (r_state == S_FIN) begin
        if (!r_dbz) begin
          r_hi <= w_hi_fix;
          r_lo <= w_lo_fix;
        end
      end else if (w_idle_req && bus.op_sel == OP_MTHI) begin
        r_hi <= bus.a;
      end else if (w_idle_req && bus.op_sel == OP_MTLO) begin
        r_lo <= bus.a;
      end
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz_pulse;
  assign bus.stall       = (bus.op_valid & (w_busy | (w_arith & ~r_done)))
                         | (bus.rd_hilo & w_busy);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed scenarios plus random ops, all outputs
// compared every cycle against a latency/arithmetic reference model.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus_if ();

  muldiv_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one arithmetic op, straight from integer arithmetic.
  function automatic void model_result(input logic [2:0] op, input logic [31:0] av,
                                       input logic [31:0] bv, output logic [31:0] rh,
                                       output logic [31:0] rl, output logic dz);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     v;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'b0, av};
    ub = {32'b0, bv};
    v  = '0;
    rh = '0;
    rl = '0;
    dz = 1'b0;
    case (op)
      OP_MULTU: begin v = ua * ub; rh = v[63:32]; rl = v[31:0]; end
      OP_MULT:  begin v = sa * sb; rh = v[63:32]; rl = v[31:0]; end
      OP_DIVU: begin
        if (bv == 0) dz = 1'b1;
        else begin rl = av / bv; rh = av % bv; end
      end
      OP_DIV: begin
        if (bv == 0) dz = 1'b1;
        else begin
          q = sa / sb; r = sa % sb;
          v = q; rl = v[31:0];
          v = r; rh = v[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  // Reference model: result lands W+1 edges after acceptance (1 for divide by zero).
  logic [31:0] exp_hi = '0, exp_lo = '0, p_hi = '0, p_lo = '0;
  logic        p_dbz = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  int          m_rem = 0;
  logic [31:0] t_hi, t_lo;
  logic        t_dz;
  logic        exp_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_hi <= '0; exp_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0; m_rem <= 0;
    end else if (m_rem != 0) begin
      m_rem  <= m_rem - 1;
      m_done <= (m_rem == 1);
      m_dbz  <= (m_rem == 1) && p_dbz;
      if (m_rem == 1 && !p_dbz) begin
        exp_hi <= p_hi;
        exp_lo <= p_lo;
      end
    end else begin
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      if (bus_if.op_valid && !m_done) begin
        if (bus_if.op_sel[2] == 1'b0) begin
          model_result(bus_if.op_sel, bus_if.a, bus_if.b, t_hi, t_lo, t_dz);
          p_hi  <= t_hi;
          p_lo  <= t_lo;
          p_dbz <= t_dz;
          m_rem <= t_dz ? 1 : W + 1;
        end else if (bus_if.op_sel == OP_MTHI) exp_hi <= bus_if.a;
        else if (bus_if.op_sel == OP_MTLO) exp_lo <= bus_if.a;
      end
    end
  end

  assign exp_stall = (bus_if.op_valid & ((m_rem != 0) | (~bus_if.op_sel[2] & ~m_done)))
                   | (bus_if.rd_hilo & (m_rem != 0));

  always @(negedge clk) begin
    check("hi",          bus_if.hi,          exp_hi);
    check("lo",          bus_if.lo,          exp_lo);
    check("busy",        bus_if.busy,        m_rem != 0);
    check("done",        bus_if.done,        m_done);
    check("div_by_zero", bus_if.div_by_zero, m_dbz);
    check("stall",       bus_if.stall,       exp_stall);
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic v);
    @(posedge clk);
    #1;
    bus_if.op_valid = v;
    bus_if.op_sel   = op;
    bus_if.a        = av;
    bus_if.b        = bv;
    bus_if.rd_hilo  = 1'b0;
  endtask

  // Counts stall/busy cycles from the request cycle up to and including done.
  task automatic wait_done(input bit scramble, input bit rd_mid, output int n_stall,
                           output int n_busy, output logic saw_dbz);
    bit got;
    got = 0; n_stall = 0; n_busy = 0; saw_dbz = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus_if.stall) n_stall++;
      if (bus_if.busy)  n_busy++;
      if (bus_if.done) begin
        saw_dbz = bus_if.div_by_zero;
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        if (scramble) begin bus_if.a = $urandom; bus_if.b = $urandom; end
        if (rd_mid && c == 5) begin bus_if.op_valid = 1'b0; bus_if.rd_hilo = 1'b1; end
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles");
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int          ns, nb;
  logic        dz;
  logic [31:0] mh, ml;
  logic        md;
  logic [2:0]  rop;

  initial begin
    bus_if.op_valid = 1'b0;
    bus_if.op_sel   = 3'b000;
    bus_if.a        = '0;
    bus_if.b        = '0;
    bus_if.rd_hilo  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    model_result(OP_MULT, 32'hFFFF_FFFD, 32'd5, mh, ml, md);
    check("pin_mult", {mh, ml}, 64'hFFFF_FFFF_FFFF_FFF1);
    model_result(OP_DIV, 32'hFFFF_FFF9, 32'd2, mh, ml, md);
    check("pin_div", {mh, ml}, 64'hFFFF_FFFF_FFFF_FFFD);
    model_result(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mh, ml, md);
    check("pin_div_ovf", {mh, ml}, 64'h0000_0000_8000_0000);
    model_result(OP_DIVU, 32'd100, 32'd0, mh, ml, md);
    check("pin_dbz", md, 1);

    @(negedge clk);
    check("rst_hilo", {bus_if.hi, bus_if.lo}, 64'h0);
    check("rst_busy", bus_if.busy, 0);

    drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("mult_stall_cycles", ns, 34);
    check("mult_result", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_dbz", dz, 0);

    drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b1, 1'b0, ns, nb, dz);
    check("multu_busy_cycles", nb, W + 1);
    check("multu_result", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFE_0000_0001);

    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("div_neg_result", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("div_ovf_result", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);
    check("div_ovf_dbz", dz, 0);

    drive(OP_MTHI, 32'h1234, 32'd0, 1'b1);
    drive(OP_MTLO, 32'h5678, 32'd0, 1'b1);
    drive(OP_DIVU, 32'd100, 32'd0, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("dbz_busy_cycles", nb, 1);
    check("dbz_flag", dz, 1);
    check("dbz_hilo_kept", {bus_if.hi, bus_if.lo}, 64'h0000_1234_0000_5678);

    drive(OP_DIVU, 32'd100, 32'd7, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("divu_result", {bus_if.hi, bus_if.lo}, {32'd2, 32'd14});
    drive(OP_MULTU, 32'd3, 32'd4, 1'b1);
    wait_done(1'b0, 1'b1, ns, nb, dz);
    check("b2b_multu_result", {bus_if.hi, bus_if.lo}, {32'd0, 32'd12});
    check("rd_hilo_stall_cycles", ns, 34);

    drive(OP_MULT, 32'd7, 32'd9, 1'b1);
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus_if.op_valid = 1'b0;
    #1;
    check("async_rst_hilo", {bus_if.hi, bus_if.lo}, 64'h0);
    check("async_rst_busy", bus_if.busy, 0);
    check("async_rst_stall", bus_if.stall, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    drive(OP_MULT, 32'hFFFF_FFF0, 32'd3, 1'b1);
    wait_done(1'b0, 1'b0, ns, nb, dz);
    check("post_rst_mult", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFD0);
    check("post_rst_busy_cycles", nb, W + 1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      drive(rop, pick_operand(), pick_operand(), 1'b1);
      if (rop[2] == 1'b0) begin
        wait_done(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ns, nb, dz);
      end else begin
        bus_if.rd_hilo = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(3'b000, 32'd0, 32'd0, 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end

    drive(3'b000, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2000000");
    $fatal(1, "watchdog");
  end

endmodule
